// File: rtl/display_timing_pkg.sv
// Shared timing defaults, total-period helpers and scan FSM state type
// for the frame-buffer read side of the display adapter.
package display_timing_pkg;

  // Default 640x480 timing and datapath sizes.
  localparam int DEF_ADDR_W   = 20;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_RD_LAT   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } scan_state_t;

  // Clocks per line, including blanking.
  function automatic int h_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Lines per frame, including blanking.
  function automatic int v_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/raster_timing_gen.sv
// Raster position counters plus the raw (undelayed) active, sync and
// end-of-frame decodes. Counters sit at 0 while run is low.
module raster_timing_gen
  import display_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic active,
  output logic hsync_raw,
  output logic vsync_raw,
  output logic eof
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] hcnt_reg;
  logic [VW-1:0] vcnt_reg;
  logic          h_last;
  logic          v_last;

  assign h_last = (int'(hcnt_reg) == H_TOTAL - 1);
  assign v_last = (int'(vcnt_reg) == V_TOTAL - 1);

  // Horizontal/vertical position; vcnt steps when hcnt wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (!run) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
    end else if (h_last) begin
      hcnt_reg <= '0;
      vcnt_reg <= v_last ? '0 : vcnt_reg + VW'(1);
    end else begin
      hcnt_reg <= hcnt_reg + HW'(1);
    end
  end

  // Decode of the current position; syncs are active-low and idle high.
  always_comb begin
    active    = 1'b0;
    hsync_raw = 1'b1;
    vsync_raw = 1'b1;
    eof       = 1'b0;
    if (run) begin
      active    = (int'(hcnt_reg) < H_ACTIVE) && (int'(vcnt_reg) < V_ACTIVE);
      hsync_raw = !((int'(hcnt_reg) >= H_ACTIVE + H_FP) &&
                    (int'(hcnt_reg) <  H_ACTIVE + H_FP + H_SYNC));
      vsync_raw = !((int'(vcnt_reg) >= V_ACTIVE + V_FP) &&
                    (int'(vcnt_reg) <  V_ACTIVE + V_FP + V_SYNC));
      eof       = h_last && v_last;
    end
  end

endmodule

// File: rtl/fb_scan_reader.sv
// Frame-buffer scan-out: raster read addresses and strobes, timing delayed
// to match RAM read latency, and registered pixel/sync outputs.
module fb_scan_reader
  import display_timing_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int RD_LAT   = DEF_RD_LAT
)
(
  input  logic              clk,
  input  logic              ResetN,
  input  logic              Enable,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              RdEn,
  input  logic [DATA_W-1:0] RdData,
  output logic [DATA_W-1:0] PixOut,
  output logic              De,
  output logic              HSync,
  output logic              VSync,
  output logic              FrameDone
);

  // A frame must fit in the addressable buffer, and the RAM needs at least one clock.
  generate
    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_size_check
      $error("fb_scan_reader: H_ACTIVE*V_ACTIVE exceeds 2**ADDR_W");
    end
    if (RD_LAT < 1) begin : g_lat_check
      $error("fb_scan_reader: RD_LAT must be at least 1");
    end
  endgenerate

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  scan_state_t       state_reg;
  scan_state_t       state_next;
  logic              run;
  logic              active;
  logic              hsync_raw;
  logic              vsync_raw;
  logic              eof;
  logic [ADDR_W-1:0] rd_addr_reg;
  // Index 0 is the RdEn stage; index RD_LAT lines up with valid RdData.
  logic [RD_LAT:0]   de_pipe_reg;
  logic [RD_LAT:0]   hs_pipe_reg;
  logic [RD_LAT:0]   vs_pipe_reg;

  assign run    = (state_reg == RUN);
  assign RdEn   = de_pipe_reg[0];
  assign RdAddr = rd_addr_reg;

  raster_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst_n     (ResetN),
    .run       (run),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw),
    .eof       (eof)
  );

  // Scan state register.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Enable only matters when idle or on the last clock of a frame, so frames are never cut short.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (Enable) state_next = RUN;
      RUN:     if (eof && !Enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read address: advance after each strobe, stop at the last pixel, clear at frame start and in idle.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      rd_addr_reg <= '0;
    end else if (!run || eof) begin
      rd_addr_reg <= '0;
    end else if (de_pipe_reg[0] && (rd_addr_reg != LAST_ADDR)) begin
      rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
    end
  end

  // Timing delay line: stage 0 is the read strobe, later stages track RAM latency.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      de_pipe_reg <= '0;
      hs_pipe_reg <= '1;
      vs_pipe_reg <= '1;
    end else begin
      de_pipe_reg <= {de_pipe_reg[RD_LAT-1:0], active};
      hs_pipe_reg <= {hs_pipe_reg[RD_LAT-1:0], hsync_raw};
      vs_pipe_reg <= {vs_pipe_reg[RD_LAT-1:0], vsync_raw};
    end
  end

  // Output register: capture the RAM word together with its delayed timing; blank outside active.
  always_ff @(posedge clk or negedge ResetN) begin
    if (!ResetN) begin
      PixOut    <= '0;
      De        <= 1'b0;
      HSync     <= 1'b1;
      VSync     <= 1'b1;
      FrameDone <= 1'b0;
    end else begin
      PixOut    <= de_pipe_reg[RD_LAT] ? RdData : '0;
      De        <= de_pipe_reg[RD_LAT];
      HSync     <= hs_pipe_reg[RD_LAT];
      VSync     <= vs_pipe_reg[RD_LAT];
      FrameDone <= eof;
    end
  end

endmodule

// File: tb/tb_fb_scan_reader.sv
// Self-checking bench for fb_scan_reader using a small 8x6 raster.
// The reference model tracks a linear position within the frame and
// derives every expected output from that position and its history.
module tb_fb_scan_reader;

  localparam int HA = 4, HFP = 1, HS = 2, HB = 1;
  localparam int VA = 3, VFP = 1, VS = 1, VB = 1;
  localparam int LAT   = 2;
  localparam int HT    = HA + HFP + HS + HB;
  localparam int VT    = VA + VFP + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        Enable = 1'b0;
  logic [19:0] RdAddr;
  logic        RdEn;
  logic [7:0]  RdData = 8'h00;
  logic [7:0]  PixOut;
  logic        De;
  logic        HSync;
  logic        VSync;
  logic        FrameDone;

  always #5 clk = ~clk;

  fb_scan_reader #(
    .ADDR_W (20), .DATA_W (8),
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VB),
    .RD_LAT (LAT)
  ) dut (
    .clk       (clk),
    .ResetN    (ResetN),
    .Enable    (Enable),
    .RdAddr    (RdAddr),
    .RdEn      (RdEn),
    .RdData    (RdData),
    .PixOut    (PixOut),
    .De        (De),
    .HSync     (HSync),
    .VSync     (VSync),
    .FrameDone (FrameDone)
  );

  // RAM responder with two clocks of read latency.
  logic [7:0] mem [0:15];
  logic [7:0] ram_q1 = 8'h00;
  always @(posedge clk) begin
    ram_q1 <= RdEn ? mem[RdAddr[3:0]] : 8'h00;
    RdData <= ram_q1;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: m_k is the frame position of the current clock,
  // hist[j] the position of the clock j+1 cycles back (-1 = idle).
  bit m_run;
  int m_k;
  int hist [0:7];

  function automatic bit is_act(input int p);
    return (p >= 0) && ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic int addr_of(input int p);
    return (p / HT) * HA + (p % HT);
  endfunction

  function automatic bit hs_low(input int p);
    return (p >= 0) && ((p % HT) >= HA + HFP) && ((p % HT) < HA + HFP + HS);
  endfunction

  function automatic bit vs_low(input int p);
    return (p >= 0) && ((p / HT) >= VA + VFP) && ((p / HT) < VA + VFP + VS);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    total++;
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, req);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_k   = 0;
    for (int i = 0; i < 8; i++) hist[i] = -1;
  endtask

  task automatic model_edge();
    int prev;
    prev = m_run ? m_k : -1;
    if (!ResetN) begin
      model_reset();
    end else begin
      if (!m_run) begin
        if (Enable) begin
          m_run = 1'b1;
          m_k   = 0;
        end
      end else if (m_k == FRAME - 1) begin
        m_k = 0;
        if (!Enable) m_run = 1'b0;
      end else begin
        m_k++;
      end
      for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = prev;
    end
  endtask

  task automatic check_all();
    int pd;
    bit exp_de;
    pd     = hist[LAT+1];
    exp_de = is_act(pd);
    chk("RdEn", 32'(RdEn), 32'(is_act(hist[0])));
    if (is_act(hist[0]))
      chk("RdAddr", 32'(RdAddr), 32'(addr_of(hist[0])));
    else if (hist[0] < 0)
      chk("RdAddr_idle", 32'(RdAddr), 32'd0);
    chk("De", 32'(De), 32'(exp_de));
    chk("PixOut", 32'(PixOut), exp_de ? 32'(mem[addr_of(pd)]) : 32'd0);
    chk("HSync", 32'(HSync), 32'(!hs_low(pd)));
    chk("VSync", 32'(VSync), 32'(!vs_low(pd)));
    chk("FrameDone", 32'(FrameDone), 32'(hist[0] == FRAME - 1));
    $display("cyc=%0d en=%0b rden=%0b addr=%0d de=%0b pix=%02h hs=%0b vs=%0b fd=%0b",
             cyc, Enable, RdEn, RdAddr, De, PixOut, HSync, VSync, FrameDone);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  // mode 0: Enable held at want; mode 1: random mid-frame, want at frame boundary and in idle.
  task automatic run_cycles(input int n, input int mode, input bit want);
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && m_run && m_k != FRAME - 1) Enable = 1'($urandom_range(0, 1));
      else Enable = want;
      step();
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) mem[a] = 8'(a + 16);
    model_reset();
    ResetN = 1'b0;
    Enable = 1'b0;
    repeat (3) step();
    ResetN = 1'b1;

    // Idle after reset: nothing moves.
    run_cycles(100, 0, 1'b0);

    // First frame, then drop Enable part way into line 1 of the next frame.
    run_cycles(FRAME, 0, 1'b1);
    run_cycles(HT + int'($urandom_range(0, HT - 1)), 0, 1'b1);
    run_cycles(FRAME + 60, 1, 1'b0);

    // Fresh random picture, three back-to-back frames, then stop.
    for (int a = 0; a < 16; a++) mem[a] = 8'($urandom);
    run_cycles(3 * FRAME, 0, 1'b1);
    run_cycles(FRAME + 10, 1, 1'b0);

    // Asynchronous reset in the middle of a line, between clock edges.
    run_cycles(FRAME / 2 + int'($urandom_range(0, 15)), 0, 1'b1);
    #2;
    ResetN = 1'b0;
    model_reset();
    #1;
    check_all();
    repeat (2) step();
    ResetN = 1'b1;
    run_cycles(FRAME, 0, 1'b1);
    run_cycles(FRAME + 10, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
